// File: rtl/mux_scan_pkg.sv
// Shared types and sizes for the 4-channel mux scan controller.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package mux_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_PRESENT = 2'd2
    } state_t;

    localparam int CH_COUNT = 4;
    localparam int SEL_W    = 2;
    localparam int CNT_W    = 4;

    // Lowest enabled channel at or above 'from'. Returns CH_COUNT (MSB set)
    // when no enabled channel remains, which the controller reads as "done".
    function automatic logic [SEL_W:0] next_enabled(input logic [CH_COUNT-1:0] mask,
                                                    input logic [SEL_W:0]      from);
        logic [SEL_W:0] r;
        r = (SEL_W+1)'(CH_COUNT);
        for (int i = CH_COUNT-1; i >= 0; i--) begin
            if (mask[i] && (i >= int'(from))) begin
                r = (SEL_W+1)'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_scan_ctrl_settle_timer.sv
// Loadable down-counter that times how long each mux select is held.
// Latency: last_o is registered state, asserted while the count equals 1.
// Backpressure: none; load_i wins over dec_i, and the count stops at zero.
module settle_timer
    import mux_scan_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             last_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: reload takes priority, otherwise count down and saturate at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Count register with synchronous reset to zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans a 4:1 mux through channels 0..3 and returns the sampled bits as one word.
// Latency: VALID rises 4*SETTLE_CYCLES edges after START (or enabled*SETTLE_CYCLES when masked).
// Backpressure: DATA/VALID hold until READY; START is ignored while BUSY. Option macro: MUX_SCAN_MASK_EN.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                START,
`ifdef MUX_SCAN_MASK_EN
    input  logic [CH_COUNT-1:0] CH_MASK,
`endif
    input  logic                MUX_OUT,
    input  logic                READY,
    output logic                S1,
    output logic                S0,
    output logic [CH_COUNT-1:0] DATA,
    output logic                VALID,
    output logic                BUSY
);

    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES);

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [CH_COUNT-1:0] data_q, data_d;
    logic                valid_q, valid_d;

    logic                tmr_load;
    logic                tmr_dec;
    logic                tmr_last;

    // first_ch: channel selected when a scan starts; next_ch: channel after sel_q.
    // MSB set on either means "no channel left to visit".
    logic [SEL_W:0]      first_ch;
    logic [SEL_W:0]      next_ch;

`ifdef MUX_SCAN_MASK_EN
    logic [CH_COUNT-1:0] mask_q, mask_d;

    assign first_ch = next_enabled(CH_MASK, '0);
    assign next_ch  = next_enabled(mask_q, {1'b0, sel_q} + (SEL_W+1)'(1));

    // Mask is captured at the START acceptance edge and held for the whole scan.
    always_comb begin
        mask_d = mask_q;
        if ((state_q == ST_IDLE) && START) begin
            mask_d = CH_MASK;
        end
    end

    // Captured mask register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end
`else
    assign first_ch = '0;
    assign next_ch  = {1'b0, sel_q} + (SEL_W+1)'(1);
`endif

    settle_timer u_settle_timer (
        .clk_i      (CLK),
        .rst_i      (RESET),
        .load_i     (tmr_load),
        .load_val_i (SETTLE_LD),
        .dec_i      (tmr_dec),
        .last_o     (tmr_last)
    );

    // Scan sequencing: start, per-channel settle/capture, then hold the word for READY.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        data_d   = data_q;
        valid_d  = valid_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    data_d  = '0;
                    valid_d = 1'b0;
                    if (first_ch[SEL_W]) begin
                        // Nothing enabled: skip settling, publish an all-zero word next edge.
                        state_d = ST_PRESENT;
                    end else begin
                        sel_d    = first_ch[SEL_W-1:0];
                        tmr_load = 1'b1;
                        state_d  = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                if (tmr_last) begin
                    data_d[sel_q] = MUX_OUT;
                    if (next_ch[SEL_W]) begin
                        tmr_dec = 1'b1;
                        valid_d = 1'b1;
                        state_d = ST_PRESENT;
                    end else begin
                        sel_d    = next_ch[SEL_W-1:0];
                        tmr_load = 1'b1;
                    end
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_PRESENT: begin
                if (!valid_q) begin
                    // Only reached by the empty-mask path.
                    valid_d = 1'b1;
                end else if (READY) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller registers; reset discards any partial word.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign S1    = sel_q[1];
    assign S0    = sel_q[0];
    assign DATA  = data_q;
    assign VALID = valid_q;
    assign BUSY  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: three instances (N=1, N=3, N=2) each with a behavioural 4:1 mux.
// Expected words are queued when START is driven; a negedge monitor pops them on each VALID rise.
// Mask scenarios run when MUX_SCAN_MASK_EN is defined.
module tb_mux_scan_ctrl;

    typedef struct {
        int         inst;
        logic [3:0] data;
        int         vcyc;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [2:0] start;
    logic [2:0] ready;
    logic [2:0] s1, s0, valid, busy, mux_out;
    logic [3:0] data [3];
    logic [3:0] inv  [3];
    logic [2:0] vprev;
`ifdef MUX_SCAN_MASK_EN
    logic [3:0] cm;
`endif

    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Gate-level mux stand-in: OUT = IN[S1:S0].
    assign mux_out[0] = inv[0][{s1[0], s0[0]}];
    assign mux_out[1] = inv[1][{s1[1], s0[1]}];
    assign mux_out[2] = inv[2][{s1[2], s0[2]}];

    mux_scan_ctrl #(.SETTLE_CYCLES(1)) u_dut1 (
        .CLK(clk), .RESET(rst), .START(start[0]),
`ifdef MUX_SCAN_MASK_EN
        .CH_MASK(cm),
`endif
        .MUX_OUT(mux_out[0]), .READY(ready[0]), .S1(s1[0]), .S0(s0[0]),
        .DATA(data[0]), .VALID(valid[0]), .BUSY(busy[0]));

    mux_scan_ctrl #(.SETTLE_CYCLES(3)) u_dut3 (
        .CLK(clk), .RESET(rst), .START(start[1]),
`ifdef MUX_SCAN_MASK_EN
        .CH_MASK(cm),
`endif
        .MUX_OUT(mux_out[1]), .READY(ready[1]), .S1(s1[1]), .S0(s0[1]),
        .DATA(data[1]), .VALID(valid[1]), .BUSY(busy[1]));

    mux_scan_ctrl #(.SETTLE_CYCLES(2)) u_dut2 (
        .CLK(clk), .RESET(rst), .START(start[2]),
`ifdef MUX_SCAN_MASK_EN
        .CH_MASK(cm),
`endif
        .MUX_OUT(mux_out[2]), .READY(ready[2]), .S1(s1[2]), .S0(s0[2]),
        .DATA(data[2]), .VALID(valid[2]), .BUSY(busy[2]));

    task automatic check(input string name, input int act, input int exp_v);
        vectors++;
        if (act != exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic int sel(input int k);
        return int'({s1[k], s0[k]});
    endfunction

    // Drive START for one edge on instance k and queue the word expected lat edges later.
    task automatic pulse_start(input int k, input logic [3:0] exp_d, input int lat);
        exp_t e;
        e.inst = k;
        e.data = exp_d;
        e.vcyc = cyc + 1 + lat;
        sb.push_back(e);
        start[k] = 1'b1;
        tick();
        start[k] = 1'b0;
    endtask

    task automatic wait_valid(input int k);
        for (int i = 0; i < 100 && !valid[k]; i++) tick();
        check("valid_timeout", int'(valid[k]), 1);
    endtask

    // Scoreboard monitor: every VALID rise must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            if (valid[k] && !vprev[k]) begin
                if (sb.size() == 0) begin
                    check("unexpected_valid", k, -1);
                end else begin
                    e = sb.pop_front();
                    check("sb_inst", k, e.inst);
                    check("sb_data", int'(data[k]), int'(e.data));
                    check("sb_latency", cyc, e.vcyc);
                end
            end
        end
        vprev <= valid;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        rst    = 1'b1;
        start  = '0;
        ready  = '0;
        vprev  = '0;
        inv[0] = '0;
        inv[1] = '0;
        inv[2] = '0;
`ifdef MUX_SCAN_MASK_EN
        cm = 4'b1111;
`endif
        repeat (3) tick();
        for (int k = 0; k < 3; k++) begin
            check("reset_sel",   sel(k), 0);
            check("reset_data",  int'(data[k]), 0);
            check("reset_valid", int'(valid[k]), 0);
            check("reset_busy",  int'(busy[k]), 0);
        end
        rst = 1'b0;
        tick();

        // N=1 scan, IN=1,0,1,0, READY high: select walks 0..3, VALID at E0+4.
        inv[0]   = 4'b0101;
        ready[0] = 1'b1;
        pulse_start(0, 4'b0101, 4);
        for (int i = 0; i < 4; i++) begin
            check("n1_sel_seq", sel(0), i);
            check("n1_busy", int'(busy[0]), 1);
            tick();
        end
        check("n1_valid", int'(valid[0]), 1);
        check("n1_sel_hold", sel(0), 3);
        start[0] = 1'b1;                    // present at the handshake edge
        tick();
        check("n1_valid_drop", int'(valid[0]), 0);
        check("n1_busy_drop", int'(busy[0]), 0);
        check("n1_sel_after", sel(0), 3);
        start[0] = 1'b0;
        tick();
        check("hs_start_ignored", int'(busy[0]), 0);

        // Back-to-back scan with new mux inputs 0,1,1,0.
        inv[0] = 4'b0110;
        pulse_start(0, 4'b0110, 4);
        wait_valid(0);
        tick();
        check("b2b_valid_drop", int'(valid[0]), 0);
        ready[0] = 1'b0;

        // N=3 scan, READY held low 5 cycles, START pulses ignored throughout.
        inv[1]   = 4'b0101;
        ready[1] = 1'b0;
        pulse_start(1, 4'b0101, 12);
        for (int i = 0; i < 11; i++) begin
            start[1] = (i == 2 || i == 7);
            tick();
        end
        start[1] = 1'b0;
        wait_valid(1);
        for (int i = 0; i < 5; i++) begin
            check("n3_hold_valid", int'(valid[1]), 1);
            check("n3_hold_data", int'(data[1]), 4'b0101);
            check("n3_hold_busy", int'(busy[1]), 1);
            start[1] = (i == 1);
            tick();
        end
        ready[1] = 1'b1;
        start[1] = 1'b1;
        tick();
        check("n3_valid_drop", int'(valid[1]), 0);
        check("n3_busy_drop", int'(busy[1]), 0);
        ready[1] = 1'b0;
        start[1] = 1'b0;
        repeat (3) tick();
        check("n3_idle_after", int'(busy[1]), 0);

        // Reset in the middle of an N=1 scan: partial word is discarded.
        inv[0]   = 4'b1111;
        ready[0] = 1'b1;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        tick();
        check("mid_partial_data", int'(data[0]), 1);
        check("mid_sel", sel(0), 1);
        rst = 1'b1;
        tick();
        check("rst_sel",   sel(0), 0);
        check("rst_data",  int'(data[0]), 0);
        check("rst_valid", int'(valid[0]), 0);
        check("rst_busy",  int'(busy[0]), 0);
        rst = 1'b0;
        repeat (8) tick();
        check("rst_stays_idle", int'(busy[0]), 0);
        ready[0] = 1'b0;

`ifdef MUX_SCAN_MASK_EN
        // Mask 1010, N=2: only channels 1 and 3 visited.
        inv[2]   = 4'b0101;
        cm       = 4'b1010;
        ready[2] = 1'b1;
        pulse_start(2, 4'b0000, 4);
        check("mask_sel0", sel(2), 1);
        tick();
        check("mask_sel1", sel(2), 1);
        tick();
        check("mask_sel2", sel(2), 3);
        tick();
        check("mask_sel3", sel(2), 3);
        tick();
        check("mask_valid", int'(valid[2]), 1);
        tick();
        check("mask_valid_drop", int'(valid[2]), 0);

        inv[2] = 4'b1010;
        pulse_start(2, 4'b1010, 4);
        wait_valid(2);
        tick();

        // Empty mask: VALID one edge after START, select untouched.
        cm = 4'b0000;
        pulse_start(2, 4'b0000, 1);
        check("m0_sel", sel(2), 3);
        check("m0_busy", int'(busy[2]), 1);
        check("m0_valid_low", int'(valid[2]), 0);
        tick();
        check("m0_valid", int'(valid[2]), 1);
        check("m0_sel_hold", sel(2), 3);
        tick();
        check("m0_busy_drop", int'(busy[2]), 0);
        cm = 4'b1111;
`else
        // N=2 full scan on the third instance.
        inv[2]   = 4'b1001;
        ready[2] = 1'b1;
        pulse_start(2, 4'b1001, 8);
        wait_valid(2);
        tick();
        check("n2_busy_drop", int'(busy[2]), 0);
`endif
        ready[2] = 1'b0;

        repeat (2) tick();
        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
